// File: rtl/light_tx_framer.sv
// light_tx_framer: buffered, framed LED transmitter with NRZ or Manchester line coding
module light_tx_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1,
   parameter int MANCHESTER = 0
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic [DATA_WIDTH-1:0]                 data,
   input  logic                                  data_valid,
   output logic                                  data_ready,
   output logic                                  led,
   output logic                                  done,
   output logic                                  busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int BW = $clog2(BIT_CYCLES);
   localparam int IW = $clog2(DATA_WIDTH+1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [BW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;
   logic [DATA_WIDTH-1:0] sh, sh_n;
   logic par, par_n, push, pop, empty, last, load, bit_n, coded, led_n, done_n;
   assign data_ready = fifo_count != CW'(FIFO_DEPTH);
   assign empty      = fifo_count == '0;
   assign push       = data_valid && data_ready;
   assign busy       = state != IDLE;
   // FIFO storage; contents need no reset since the count gates every read
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= data;
   // FIFO pointers and occupancy
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   // Next state plus the line value for the next cycle, so led is a pure register
   always_comb begin
      state_n = state;
      idx_n   = idx;
      sh_n    = sh;
      par_n   = par;
      pop     = 1'b0;
      load    = 1'b0;
      last    = cnt == BW'(BIT_CYCLES-1);
      case (state)
         IDLE:   load = !empty && enable;
         START:  if (last) begin
                    state_n = DATA;
                    idx_n   = '0;
                 end
         DATA:   if (last) begin
                    sh_n  = sh << 1;
                    idx_n = idx + 1'b1;
                    if (idx == IW'(DATA_WIDTH-1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                 end
         PARITY: if (last) state_n = STOP;
         STOP:   if (last) begin
                    state_n = IDLE;
                    load    = !empty && enable;
                 end
         default: state_n = IDLE;
      endcase
      cnt_n = (last || state == IDLE) ? '0 : cnt + 1'b1;
      if (load) begin
         pop     = 1'b1;
         sh_n    = mem[rd_ptr];
         par_n   = ^mem[rd_ptr];
         state_n = START;
      end
      bit_n  = state_n == START ? 1'b1 : state_n == DATA ? sh_n[DATA_WIDTH-1] : state_n == PARITY ? par_n : 1'b0;
      coded  = (MANCHESTER != 0) && (state_n inside {START, DATA, PARITY}) && (cnt_n >= BW'(BIT_CYCLES/2));
      led_n  = bit_n ^ coded;
      done_n = state_n == STOP && cnt_n == BW'(BIT_CYCLES-1);
   end
   // Framer state and registered line outputs
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         par   <= 1'b0;
         led   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         par   <= par_n;
         led   <= led_n;
         done  <= done_n;
      end
endmodule

// File: tb/tb_light_tx_framer.sv
// tb_light_tx_framer: directed checks of framing, buffering, coding and reset behaviour
module tb_light_tx_framer;
   logic clock = 1'b0, reset = 1'b0, enable = 1'b0;
   logic [7:0] data = '0, m_data = '0;
   logic data_valid = 1'b0, m_valid = 1'b0;
   logic data_ready, led, done, busy, m_ready, m_led, m_done, m_busy;
   logic [2:0] fifo_count, m_count;
   logic [255:0] lv, dv, bv;
   int checks = 0, errors = 0;

   light_tx_framer dut (
      .clock(clock), .reset(reset), .enable(enable), .data(data), .data_valid(data_valid),
      .data_ready(data_ready), .led(led), .done(done), .busy(busy), .fifo_count(fifo_count));

   light_tx_framer #(.PARITY_EN(0), .MANCHESTER(1)) mdut (
      .clock(clock), .reset(reset), .enable(enable), .data(m_data), .data_valid(m_valid),
      .data_ready(m_ready), .led(m_led), .done(m_done), .busy(m_busy), .fifo_count(m_count));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cap(input int n, input bit m);
      for (int k = 0; k < n; k++) begin
         lv = {lv[254:0], m ? m_led : led};
         dv = {dv[254:0], m ? m_done : done};
         bv = {bv[254:0], m ? m_busy : busy};
         tick();
      end
   endtask

   function automatic logic [43:0] nrz(input logic [7:0] w);
      logic [10:0] b;
      logic [43:0] v;
      b = {1'b1, w, ^w, 1'b0};
      v = '0;
      for (int i = 10; i >= 0; i--) v = {v[39:0], {4{b[i]}}};
      return v;
   endfunction

   initial begin
      #1 reset = 1'b1;
      #2;
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", data_ready, 1);
      chk("rst_count", fifo_count, 0);
      tick();
      reset = 1'b0;
      enable = 1'b1;
      tick();
      // single NRZ frame
      data = 8'hB6; data_valid = 1'b1; tick(); data_valid = 1'b0;
      tick();
      lv = '0; dv = '0; bv = '0;
      cap(44, 0);
      chk("b6_led", lv, nrz(8'hB6));
      chk("b6_done", dv, 44'h1);
      chk("b6_busy", bv, {44{1'b1}});
      chk("b6_idle", busy, 0);
      // back-to-back frames
      data = 8'hB6; data_valid = 1'b1; tick();
      data = 8'hF4; tick(); data_valid = 1'b0;
      lv = '0; dv = '0;
      cap(88, 0);
      chk("b2b_led", lv, {nrz(8'hB6), nrz(8'hF4)});
      chk("b2b_done", dv, {44'h1, 44'h1});
      chk("b2b_idle", busy, 0);
      // backpressure with enable low
      enable = 1'b0;
      data_valid = 1'b1;
      data = 8'h01; tick();
      data = 8'h02; tick();
      data = 8'h03; tick();
      data = 8'h04; tick();
      chk("bp_ready", data_ready, 0);
      chk("bp_full", fifo_count, 4);
      data = 8'h05; tick(); data_valid = 1'b0;
      chk("bp_drop", fifo_count, 4);
      chk("bp_noframe", busy, 0);
      enable = 1'b1;
      tick();
      chk("bp_ready_back", data_ready, 1);
      chk("bp_count3", fifo_count, 3);
      lv = '0; dv = '0;
      cap(176, 0);
      chk("bp_led", lv, {nrz(8'h01), nrz(8'h02), nrz(8'h03), nrz(8'h04)});
      chk("bp_done", dv, {44'h1, 44'h1, 44'h1, 44'h1});
      chk("bp_idle", busy, 0);
      chk("bp_empty", fifo_count, 0);
      // Manchester frame without parity
      m_data = 8'h80; m_valid = 1'b1; tick(); m_valid = 1'b0;
      tick();
      lv = '0; dv = '0;
      cap(40, 1);
      chk("man_led", lv, 40'hCC33333330);
      chk("man_done", dv, 40'h1);
      chk("man_idle", m_busy, 0);
      // asynchronous reset mid-frame
      data = 8'hFF; data_valid = 1'b1; tick(); tick(); tick(); data_valid = 1'b0;
      repeat (20) tick();
      chk("mid_led", led, 1);
      chk("mid_count", fifo_count, 2);
      chk("mid_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_led", led, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_ready", data_ready, 1);
      tick();
      reset = 1'b0;
      lv = '0; bv = '0;
      cap(10, 0);
      chk("post_rst_led", lv, 0);
      chk("post_rst_busy", bv, 0);
      // enable dropped mid-frame
      data = 8'hAA; data_valid = 1'b1; tick();
      data = 8'h55; tick(); data_valid = 1'b0;
      lv = '0; dv = '0;
      cap(10, 0);
      enable = 1'b0;
      cap(34, 0);
      chk("en_led", lv, nrz(8'hAA));
      chk("en_done", dv, 44'h1);
      chk("en_idle", busy, 0);
      chk("en_count", fifo_count, 1);
      repeat (3) tick();
      chk("en_hold_busy", busy, 0);
      chk("en_hold_count", fifo_count, 1);
      enable = 1'b1;
      tick();
      chk("en_restart_busy", busy, 1);
      chk("en_restart_count", fifo_count, 0);
      lv = '0; dv = '0;
      cap(44, 0);
      chk("en_55_led", lv, nrz(8'h55));
      chk("en_55_done", dv, 44'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
